// File: rtl/stab_pkg.sv
// Shared definitions for the stability sweep sequencer: FSM states, mode codes
// and the layout of the result tag attached to every captured sample.
package stab_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DC_SETTLE,
    S_DC_MEAS,
    S_AC_SETTLE,
    S_AC_MEAS,
    S_SP_SETTLE,
    S_SP_MEAS,
    S_FIN
  } state_e;

  localparam logic [1:0] MODE_IDLE = 2'd0;
  localparam logic [1:0] MODE_DC   = 2'd1;
  localparam logic [1:0] MODE_AC   = 2'd2;
  localparam logic [1:0] MODE_SP   = 2'd3;

  localparam int TAG_W         = 20;
  localparam int TAG_POINT_LSB = 0;
  localparam int TAG_PROBE_BIT = 16;
  localparam int TAG_PORT_BIT  = 17;
  localparam int TAG_MODE_LSB  = 18;

  function automatic logic [TAG_W-1:0] make_tag(input logic [1:0] mode, input logic port,
                                                input logic probe, input logic [15:0] point);
    logic [TAG_W-1:0] t;
    t = '0;
    t[TAG_MODE_LSB +: 2]   = mode;
    t[TAG_PORT_BIT]        = port;
    t[TAG_PROBE_BIT]       = probe;
    t[TAG_POINT_LSB +: 16] = point;
    return t;
  endfunction

endpackage

// File: rtl/stab_timer.sv
// Loadable down-counter shared by settle timing and sample-ack timeout.
// Load has priority over decrement; the counter parks at zero.
module stab_timer #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/stab_sweep_seq.sv
// Stability sweep sequencer: DC bias check, AC loop-gain sweep and two-port SP
// sweep, issuing sampler requests and tagging each captured sample.
module stab_sweep_seq
  import stab_pkg::*;
#(
  parameter int TIMEOUT = 255,
  parameter int FW      = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  input  logic [FW-1:0] f_start,
  input  logic [FW-1:0] f_step,
  input  logic [15:0]   n_points,
  input  logic [15:0]   settle_cyc,
  input  logic          smp_ack,
  input  logic [31:0]   smp_data,
  output logic [1:0]    mode,
  output logic [FW-1:0] freq,
  output logic          freq_valid,
  output logic          inj_en,
  output logic          port_sel,
  output logic          probe_sel,
  output logic          smp_req,
  output logic          res_valid,
  output logic [31:0]   res_data,
  output logic [19:0]   res_tag,
  output logic          busy,
  output logic          done,
  output logic          err,
  output state_e        dbg_state
);

  localparam logic [15:0] TO_LOAD = 16'(TIMEOUT - 1);

  state_e        state_q, state_d;
  logic [1:0]    mode_q, mode_d;
  logic [FW-1:0] freq_q, freq_d, fs_q, fs_d, fst_q, fst_d;
  logic          fv_q, fv_d, inj_q, inj_d, port_q, port_d, probe_q, probe_d;
  logic          req_q, req_d, rv_q, rv_d, busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic [31:0]   rdata_q, rdata_d;
  logic [19:0]   rtag_q, rtag_d;
  logic [15:0]   point_q, point_d, npts_q, npts_d, settle_q, settle_d;
  logic          tmr_load, tmr_dec, tmr_zero, last_pt, quiesce;
  logic [15:0]   tmr_val;

  // Settle states hold max(settle,1) cycles, so the counter is loaded one short.
  function automatic logic [15:0] settle_load(input logic [15:0] s);
    return (s == 16'd0) ? 16'd0 : s - 16'd1;
  endfunction

  stab_timer #(.W(16)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .dec      (tmr_dec),
    .zero     (tmr_zero)
  );

  assign last_pt = (point_q == npts_q - 16'd1);

  always_comb begin
    state_d = state_q;  mode_d = mode_q;   freq_d = freq_q;   fv_d = fv_q;
    inj_d = inj_q;      port_d = port_q;   probe_d = probe_q; req_d = req_q;
    rv_d = 1'b0;        rdata_d = rdata_q; rtag_d = rtag_q;   busy_d = busy_q;
    done_d = 1'b0;      err_d = 1'b0;      point_d = point_q; fs_d = fs_q;
    fst_d = fst_q;      npts_d = npts_q;   settle_d = settle_q;
    tmr_load = 1'b0;    tmr_dec = 1'b0;    tmr_val = settle_load(settle_q);
    quiesce = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          fs_d = f_start;  fst_d = f_step;  npts_d = n_points;  settle_d = settle_cyc;
          tmr_load = 1'b1; tmr_val = settle_load(settle_cyc);
          state_d = S_DC_SETTLE; busy_d = 1'b1; mode_d = MODE_DC;
          point_d = '0; probe_d = 1'b0; port_d = 1'b0;
        end
      end
      S_DC_SETTLE, S_AC_SETTLE, S_SP_SETTLE: begin
        if (tmr_zero) begin
          state_d  = (state_q == S_DC_SETTLE) ? S_DC_MEAS :
                     (state_q == S_AC_SETTLE) ? S_AC_MEAS : S_SP_MEAS;
          req_d    = 1'b1;
          tmr_load = 1'b1;
          tmr_val  = TO_LOAD;
        end else begin
          tmr_dec = 1'b1;
        end
      end
      S_DC_MEAS, S_AC_MEAS, S_SP_MEAS: begin
        if (!req_q) begin
          req_d = 1'b1; tmr_load = 1'b1; tmr_val = TO_LOAD;
        end else if (smp_ack) begin
          req_d = 1'b0; rv_d = 1'b1; rdata_d = smp_data;
          rtag_d = make_tag(mode_q, port_q, probe_q, point_q);
          probe_d = ~probe_q;
          if (probe_q) begin
            // Both probes done: move on; any SETTLE entry reloads the settle time.
            tmr_load = 1'b1;
            case (state_q)
              S_DC_MEAS: begin
                if (npts_q == 16'd0) begin
                  state_d = S_FIN; done_d = 1'b1; quiesce = 1'b1;
                end else begin
                  state_d = S_AC_SETTLE; mode_d = MODE_AC; inj_d = 1'b1;
                  fv_d = 1'b1; freq_d = fs_q; point_d = '0;
                end
              end
              S_AC_MEAS: begin
                if (last_pt) begin
                  state_d = S_SP_SETTLE; mode_d = MODE_SP; inj_d = 1'b0;
                  freq_d = fs_q; point_d = '0; port_d = 1'b0;
                end else begin
                  state_d = S_AC_SETTLE; point_d = point_q + 16'd1; freq_d = freq_q + fst_q;
                end
              end
              default: begin
                if (!port_q) begin
                  state_d = S_SP_SETTLE; port_d = 1'b1;
                end else if (last_pt) begin
                  state_d = S_FIN; done_d = 1'b1; quiesce = 1'b1;
                end else begin
                  state_d = S_SP_SETTLE; port_d = 1'b0;
                  point_d = point_q + 16'd1; freq_d = freq_q + fst_q;
                end
              end
            endcase
          end
        end else if (tmr_zero) begin
          state_d = S_IDLE; err_d = 1'b1; quiesce = 1'b1;
        end else begin
          tmr_dec = 1'b1;
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // Abort wins over a same-cycle ack or timeout: nothing is reported.
    if (abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE; rv_d = 1'b0; done_d = 1'b0; err_d = 1'b0;
      rdata_d = rdata_q; rtag_d = rtag_q; tmr_load = 1'b0; tmr_dec = 1'b0;
      quiesce = 1'b1;
    end
    if (quiesce) begin
      busy_d = 1'b0; mode_d = MODE_IDLE; freq_d = '0; fv_d = 1'b0; inj_d = 1'b0;
      port_d = 1'b0; probe_d = 1'b0; req_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE; mode_q <= MODE_IDLE; freq_q <= '0; fv_q <= 1'b0; inj_q <= 1'b0;
      port_q <= 1'b0; probe_q <= 1'b0; req_q <= 1'b0; rv_q <= 1'b0; rdata_q <= '0;
      rtag_q <= '0; busy_q <= 1'b0; done_q <= 1'b0; err_q <= 1'b0; point_q <= '0;
      fs_q <= '0; fst_q <= '0; npts_q <= '0; settle_q <= '0;
    end else begin
      state_q <= state_d; mode_q <= mode_d; freq_q <= freq_d; fv_q <= fv_d; inj_q <= inj_d;
      port_q <= port_d; probe_q <= probe_d; req_q <= req_d; rv_q <= rv_d; rdata_q <= rdata_d;
      rtag_q <= rtag_d; busy_q <= busy_d; done_q <= done_d; err_q <= err_d; point_q <= point_d;
      fs_q <= fs_d; fst_q <= fst_d; npts_q <= npts_d; settle_q <= settle_d;
    end
  end

  assign mode = mode_q;        assign freq = freq_q;       assign freq_valid = fv_q;
  assign inj_en = inj_q;       assign port_sel = port_q;   assign probe_sel = probe_q;
  assign smp_req = req_q;      assign res_valid = rv_q;    assign res_data = rdata_q;
  assign res_tag = rtag_q;     assign busy = busy_q;       assign done = done_q;
  assign err = err_q;          assign dbg_state = state_q;

endmodule

// File: tb/tb_stab_sweep_seq.sv
// Randomized bench for stab_sweep_seq against a sample-list model of the sweep.
module tb_stab_sweep_seq;
  import stab_pkg::*;

  localparam int FW = 32;
  localparam int TIMEOUT = 255;

  logic clk = 1'b0;
  logic rst, start, abort, smp_ack;
  logic [FW-1:0] f_start, f_step, freq;
  logic [15:0] n_points, settle_cyc;
  logic [31:0] smp_data, res_data;
  logic [1:0] mode;
  logic freq_valid, inj_en, port_sel, probe_sel, smp_req, res_valid, busy, done, err;
  logic [19:0] res_tag;
  state_e dbg_state;

  stab_sweep_seq #(.TIMEOUT(TIMEOUT), .FW(FW)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .f_start(f_start), .f_step(f_step),
    .n_points(n_points), .settle_cyc(settle_cyc), .smp_ack(smp_ack), .smp_data(smp_data),
    .mode(mode), .freq(freq), .freq_valid(freq_valid), .inj_en(inj_en), .port_sel(port_sel),
    .probe_sel(probe_sel), .smp_req(smp_req), .res_valid(res_valid), .res_data(res_data),
    .res_tag(res_tag), .busy(busy), .done(done), .err(err), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  mode;
    logic        port;
    logic        probe;
    logic [15:0] point;
    logic [31:0] freq;
  } smp_t;

  smp_t        model_q[$];
  logic [51:0] exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  // Every sample the sweep must take, in order, straight from the sweep rules.
  function automatic void build_model(input int n, input logic [31:0] fs, input logic [31:0] fst);
    smp_t s;
    model_q.delete();
    for (int p = 0; p < 2; p++) begin
      s = '0; s.mode = 2'd1; s.probe = p[0]; model_q.push_back(s);
    end
    for (int k = 0; k < n; k++)
      for (int p = 0; p < 2; p++) begin
        s = '0; s.mode = 2'd2; s.probe = p[0]; s.point = 16'(k);
        s.freq = fs + 32'(k) * fst; model_q.push_back(s);
      end
    for (int k = 0; k < n; k++)
      for (int pt = 0; pt < 2; pt++)
        for (int p = 0; p < 2; p++) begin
          s = '0; s.mode = 2'd3; s.port = pt[0]; s.probe = p[0]; s.point = 16'(k);
          s.freq = fs + 32'(k) * fst; model_q.push_back(s);
        end
  endfunction

  task automatic run_sweep(input string name, input int n, input logic [31:0] fs,
      input logic [31:0] fst, input int settle, input int max_dly, input int withhold_idx,
      input int abort_idx, input bit start_at_done, output int done_cyc, output int n_done,
      output int n_err, output int n_res, output int req_run);
    smp_t m;
    logic [51:0] e;
    int idx, dly, cyc;
    bit prev_ack, aborting, finished;
    build_model(n, fs, fst);
    exp_q.delete();
    idx = 0; cyc = 0; prev_ack = 0; aborting = 0; finished = 0;
    n_done = 0; n_err = 0; n_res = 0; req_run = 0; done_cyc = -1;
    dly = $urandom_range(0, max_dly);
    @(negedge clk);
    f_start = fs; f_step = fst; n_points = 16'(n); settle_cyc = 16'(settle); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n_cmp++;
    if (busy !== 1'b1) begin n_bad++; $display("FAIL %s busy_after_start: got %b want 1", name, busy); end
    while (!finished && cyc < 20000) begin
      n_cmp++;
      if (res_valid !== prev_ack) begin
        n_bad++; $display("FAIL %s res_valid_timing cyc %0d: got %b want %b", name, cyc, res_valid, prev_ack);
      end
      if (res_valid === 1'b1) begin
        n_res++; n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++; $display("FAIL %s unexpected_result: got tag %h, none expected", name, res_tag);
        end else begin
          e = exp_q.pop_front();
          if ({res_tag, res_data} !== e) begin
            n_bad++; $display("FAIL %s result: got %h/%h want %h/%h", name, res_tag, res_data, e[51:32], e[31:0]);
          end
        end
      end
      n_cmp++;
      if (inj_en !== (mode == 2'd2)) begin
        n_bad++; $display("FAIL %s inj_en: got %b with mode %0d", name, inj_en, mode);
      end
      n_cmp++;
      if (port_sel === 1'b1 && mode !== 2'd3) begin
        n_bad++; $display("FAIL %s port_sel: got 1 with mode %0d, want SP only", name, mode);
      end
      if (done === 1'b1) begin n_done++; done_cyc = cyc; finished = 1; end
      if (err === 1'b1) begin
        n_err++; finished = 1; n_cmp++;
        if (busy !== 1'b0 || smp_req !== 1'b0) begin
          n_bad++; $display("FAIL %s err_quiesce: got busy %b req %b want 0 0", name, busy, smp_req);
        end
      end
      if (aborting) begin
        finished = 1; n_cmp++;
        if (busy !== 1'b0 || mode !== 2'd0 || smp_req !== 1'b0 || dbg_state !== S_IDLE) begin
          n_bad++; $display("FAIL %s abort_idle: got busy %b mode %0d req %b state %0d want idle", name, busy, mode, smp_req, dbg_state);
        end
      end
      prev_ack = 0; smp_ack = 1'b0; abort = 1'b0; start = 1'b0;
      if (!finished) begin
        start = busy && ($urandom_range(0, 7) == 0);
        if (smp_req === 1'b1) begin
          if (idx == withhold_idx) req_run++;
          else if (dly > 0) dly--;
          else if (idx >= model_q.size()) begin
            n_cmp++; n_bad++; finished = 1;
            $display("FAIL %s extra_sample: got request %0d, want %0d total", name, idx, model_q.size());
          end else begin
            m = model_q[idx];
            n_cmp++;
            if ({mode, port_sel, probe_sel} !== {m.mode, m.port, m.probe}) begin
              n_bad++; $display("FAIL %s sample_select #%0d: got %0d/%b/%b want %0d/%b/%b", name, idx, mode, port_sel, probe_sel, m.mode, m.port, m.probe);
            end
            if (m.mode != 2'd1) begin
              n_cmp++;
              if ({freq_valid, freq} !== {1'b1, m.freq}) begin
                n_bad++; $display("FAIL %s freq #%0d: got %b/%h want 1/%h", name, idx, freq_valid, freq, m.freq);
              end
            end
            smp_data = $urandom; smp_ack = 1'b1;
            if (idx == abort_idx) begin abort = 1'b1; aborting = 1; end
            else begin
              exp_q.push_back({m.mode, m.port, m.probe, m.point, smp_data});
              prev_ack = 1;
            end
            idx++;
            dly = $urandom_range(0, max_dly);
          end
        end else if ($urandom_range(0, 3) == 0) begin
          smp_ack = 1'b1; smp_data = $urandom;
        end
        @(negedge clk);
        cyc++;
      end
    end
    smp_ack = 1'b0; start = 1'b0; abort = 1'b0;
    if (!finished) begin
      n_cmp++; n_bad++; $display("FAIL %s cycle_budget: got no end after %0d cycles", name, cyc);
    end
    if (start_at_done && done_cyc >= 0) begin
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      n_cmp++;
      if (busy !== 1'b0 || dbg_state !== S_IDLE) begin
        n_bad++; $display("FAIL %s start_at_done: got busy %b state %0d want 0 IDLE", name, busy, dbg_state);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; abort = 1'b0; smp_ack = 1'b0; smp_data = '0;
    f_start = '0; f_step = '0; n_points = '0; settle_cyc = '0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({busy, mode, freq, freq_valid, inj_en, port_sel, probe_sel, smp_req, res_valid, res_data, res_tag, done, err} !== '0) begin
      n_bad++; $display("FAIL reset_outputs: got busy %b mode %0d freq %h res %h/%h want all 0", busy, mode, freq, res_tag, res_data);
    end
    n_cmp++;
    if (dbg_state !== S_IDLE) begin n_bad++; $display("FAIL reset_state: got %0d want IDLE", dbg_state); end
    rst = 1'b0;
  endtask

  task automatic test_dc_only();
    int dc, nd, ne, nr, rr;
    run_sweep("dc_only", 0, 32'h0, 32'h0, 3, 0, -1, -1, 1'b0, dc, nd, ne, nr, rr);
    n_cmp++;
    if (nr != 2 || nd != 1 || ne != 0 || exp_q.size() != 0) begin
      n_bad++; $display("FAIL dc_only counts: got res %0d done %0d err %0d left %0d want 2 1 0 0", nr, nd, ne, exp_q.size());
    end
    n_cmp++;
    if (dc < 4 || dc > 12) begin n_bad++; $display("FAIL dc_only done_latency: got %0d want 4..12", dc); end
  endtask

  task automatic test_freq_sweep();
    int dc, nd, ne, nr, rr;
    run_sweep("freq_sweep", 3, 32'd1000000000, 32'd100000000, $urandom_range(0, 3), 3, -1, -1, 1'b1, dc, nd, ne, nr, rr);
    n_cmp++;
    if (nr != 20 || nd != 1 || ne != 0 || exp_q.size() != 0) begin
      n_bad++; $display("FAIL freq_sweep counts: got res %0d done %0d err %0d left %0d want 20 1 0 0", nr, nd, ne, exp_q.size());
    end
  endtask

  task automatic test_wrap();
    int dc, nd, ne, nr, rr;
    run_sweep("wrap", 2, 32'hFFFF_FFF0, 32'h10, 1, 2, -1, -1, 1'b0, dc, nd, ne, nr, rr);
    n_cmp++;
    if (nr != 14 || nd != 1 || ne != 0) begin
      n_bad++; $display("FAIL wrap counts: got res %0d done %0d err %0d want 14 1 0", nr, nd, ne);
    end
  endtask

  task automatic test_random();
    int dc, nd, ne, nr, rr, n;
    for (int i = 0; i < 3; i++) begin
      n = $urandom_range(1, 3);
      run_sweep("random", n, $urandom, $urandom, $urandom_range(0, 5), 4, -1, -1, 1'b1, dc, nd, ne, nr, rr);
      n_cmp++;
      if (nr != 2 + 6 * n || nd != 1 || ne != 0) begin
        n_bad++; $display("FAIL random counts n=%0d: got res %0d done %0d err %0d want %0d 1 0", n, nr, nd, ne, 2 + 6 * n);
      end
    end
  endtask

  task automatic test_timeout();
    int dc, nd, ne, nr, rr;
    run_sweep("timeout", 2, 32'd5000, 32'd250, 2, 1, 4, -1, 1'b0, dc, nd, ne, nr, rr);
    n_cmp++;
    if (ne != 1 || nd != 0 || nr != 4) begin
      n_bad++; $display("FAIL timeout counts: got err %0d done %0d res %0d want 1 0 4", ne, nd, nr);
    end
    n_cmp++;
    if (rr != TIMEOUT) begin n_bad++; $display("FAIL timeout req_cycles: got %0d want %0d", rr, TIMEOUT); end
  endtask

  task automatic test_abort();
    int dc, nd, ne, nr, rr;
    run_sweep("abort", 1, 32'd7000, 32'd10, 1, 1, -1, 4, 1'b0, dc, nd, ne, nr, rr);
    n_cmp++;
    if (nd != 0 || ne != 0 || nr != 4) begin
      n_bad++; $display("FAIL abort counts: got done %0d err %0d res %0d want 0 0 4", nd, ne, nr);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    settle_cyc = 16'd20; n_points = 16'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    n_cmp++;
    if (busy !== 1'b1 || mode !== 2'd1) begin
      n_bad++; $display("FAIL rst_mid pre: got busy %b mode %0d want 1 1", busy, mode);
    end
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({busy, mode, freq, freq_valid, inj_en, port_sel, probe_sel, smp_req, res_valid, res_data, res_tag, done, err} !== '0) begin
      n_bad++; $display("FAIL rst_mid outputs: got busy %b mode %0d res %h/%h want all 0", busy, mode, res_tag, res_data);
    end
    n_cmp++;
    if (dbg_state !== S_IDLE) begin n_bad++; $display("FAIL rst_mid state: got %0d want IDLE", dbg_state); end
    @(negedge clk);
    rst = 1'b0; start = 1'b1; settle_cyc = 16'd2; n_points = 16'd0;
    @(negedge clk);
    start = 1'b0;
    n_cmp++;
    if (busy !== 1'b1 || mode !== 2'd1) begin
      n_bad++; $display("FAIL first_start: got busy %b mode %0d want 1 1", busy, mode);
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    n_cmp++;
    if (busy !== 1'b0 || dbg_state !== S_IDLE) begin
      n_bad++; $display("FAIL abort_settle: got busy %b state %0d want 0 IDLE", busy, dbg_state);
    end
  endtask

  initial begin
    test_reset();
    test_dc_only();
    test_freq_sweep();
    test_wrap();
    test_random();
    test_timeout();
    test_abort();
    test_reset_mid();
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
